// File: rtl/vga_axi4_rd_dma.sv
// AXI4 read DMA that streams one video frame from memory into a FWFT pixel FIFO.
// One burst is outstanding at a time, and a burst is only requested when the FIFO can absorb all of it.
module vga_axi4_rd_dma #(
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned FIFO_DEPTH = 64,
  parameter logic [3:0]  AR_ID      = 4'd0
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        en_i,
  input  logic        frame_start_i,
  input  logic [31:0] base_addr_i,
  input  logic [31:0] frame_bytes_i,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [63:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        pix_valid_o,
  output logic [63:0] pix_data_o,
  input  logic        pix_ready_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);
  localparam int unsigned DATA_W      = 64;
  localparam int unsigned BURST_BYTES = BURST_LEN * 8;
  localparam int unsigned PTR_W       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LVL_W       = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, AR, R} state_t;

  state_t            state;
  logic [31:0]       cur_addr;
  logic [31:0]       burst_cnt;
  logic [31:0]       burst_cnt_dec;
  logic [7:0]        beat_cnt;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level;
  logic [LVL_W-1:0]  level_nxt;
  logic              push;
  logic              pop;
  logic              last_beat;
  logic              beat_err;
  logic              space_nxt;

  assign araddr        = cur_addr;
  assign push          = rvalid && rready;
  assign pop           = pix_valid_o && pix_ready_i;
  assign pix_valid_o   = (level != '0);
  assign pix_data_o    = fifo_mem[rd_ptr];
  assign busy_o        = (state != IDLE) || pix_valid_o;
  assign last_beat     = (beat_cnt == 8'(BURST_LEN - 1));
  assign burst_cnt_dec = burst_cnt - 32'd1;
  assign beat_err      = (rresp != 2'b00) || (rid != AR_ID) || (rlast != last_beat);

  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + LVL_W'(1);
      2'b01:   level_nxt = level - LVL_W'(1);
      default: level_nxt = level;
    endcase
  end

  // Space is judged on next cycle's level so arvalid can rise straight out of a burst end.
  assign space_nxt = (LVL_W'(FIFO_DEPTH) - level_nxt) >= LVL_W'(BURST_LEN);

  always_ff @(posedge aclk) begin
    if (push) fifo_mem[wr_ptr] <= rdata;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= IDLE;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      cur_addr  <= '0;
      burst_cnt <= '0;
      beat_cnt  <= '0;
      arlen     <= '0;
      arsize    <= '0;
      arburst   <= '0;
      arid      <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
    end else begin
      done_o <= 1'b0;
      level  <= level_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      unique case (state)
        IDLE: begin
          if (frame_start_i && en_i && (frame_bytes_i != '0)) begin
            state     <= AR;
            cur_addr  <= base_addr_i;
            burst_cnt <= frame_bytes_i / 32'(BURST_BYTES);
            arlen     <= 8'(BURST_LEN - 1);
            arsize    <= 3'd3;
            arburst   <= 2'b01;
            arid      <= AR_ID;
            arvalid   <= space_nxt;
          end
        end
        AR: begin
          if (arvalid && arready) begin
            state    <= R;
            arvalid  <= 1'b0;
            rready   <= 1'b1;
            beat_cnt <= '0;
            cur_addr <= cur_addr + 32'(BURST_BYTES);
          end else if (!arvalid) begin
            arvalid <= space_nxt;
          end
        end
        R: begin
          if (push) begin
            if (beat_err) err_o <= 1'b1;
            beat_cnt <= beat_cnt + 8'd1;
            // The beat count, not rlast, closes the burst so a bad slave cannot hang us.
            if (last_beat) begin
              rready    <= 1'b0;
              burst_cnt <= burst_cnt_dec;
              if (!en_i || (burst_cnt_dec == '0)) begin
                state  <= IDLE;
                done_o <= en_i;
              end else begin
                state   <= AR;
                arvalid <= space_nxt;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/vga_axi4_rd_dma.md
VGA_AXI4_RD_DMA -- requirements
Module: vga_axi4_rd_dma

Interface
REQ-001 SHALL have parameter BURST_LEN, default 16, meaning beats per AR burst (1..256).
REQ-002 SHALL have parameter FIFO_DEPTH, default 64, meaning R-data FIFO entries (power of 2, >= BURST_LEN).
REQ-003 SHALL have parameter AR_ID, default 0, meaning constant arid value.
REQ-004 SHALL have one clock and a synchronous, active-high reset:
- aclk  in  1  clock, all logic on rising edge.
- areset  in  1  synchronous active-high reset.
REQ-005 SHALL have these control ports:
- en_i  in  1  DMA enable.
- frame_start_i  in  1  single-cycle frame trigger (vsync).
- base_addr_i  in  AXI4_ADDR_WIDTH(32)  frame base byte address, 8-byte aligned.
- frame_bytes_i  in  32  frame size, multiple of BURST_LEN*8.
REQ-006 SHALL have these AXI4 read master ports:
- arid  out  AXI4_ID_WIDTH(4).
- araddr  out  32.
- arlen  out  8.
- arsize  out  3.
- arburst  out  2.
- arvalid  out  1.
- arready  in  1.
- rid  in  4.
- rdata  in  AXI4_DATA_WIDTH(64).
- rresp  in  2.
- rlast  in  1.
- rvalid  in  1.
- rready  out  1.
REQ-007 SHALL have these pixel stream and status ports:
- pix_valid_o  out  1.
- pix_data_o  out  64.
- pix_ready_i  in  1.
- busy_o  out  1.
- done_o  out  1  one-cycle pulse.
- err_o  out  1  sticky.

Function
REQ-008 SHALL implement states IDLE, AR, R.
REQ-009 SHALL leave IDLE for AR when frame_start_i=1, en_i=1 and frame_bytes_i!=0, latching base_addr_i into cur_addr and frame_bytes_i/(BURST_LEN*8) into burst_cnt.
REQ-010 SHALL ignore frame_start_i while not in IDLE.
REQ-011 SHALL, in AR, assert arvalid only when FIFO free entries >= BURST_LEN, with:
- araddr = cur_addr.
- arlen = BURST_LEN-1.
- arsize = 3.
- arburst = INCR (2'b01).
- arid = AR_ID.
REQ-012 SHALL hold all AR fields stable while arvalid=1 and arready=0, and SHALL never deassert arvalid before the handshake.
REQ-013 SHALL, on the AR handshake, move to R and add BURST_LEN*8 to cur_addr (32-bit wrap, no 4 KB check).
REQ-014 SHALL have at most one outstanding burst.
REQ-015 SHALL drive rready=1 in R only (FIFO space is guaranteed by REQ-011).
REQ-016 SHALL push rdata into the FIFO on every R handshake.
REQ-017 SHALL set err_o on an R handshake when rresp!=OKAY, when rid!=AR_ID, or when rlast disagrees with beat index==BURST_LEN-1.
REQ-018 SHALL end a burst on the final counted beat (BURST_LEN beats), regardless of rlast.
REQ-019 SHALL, at burst end, decrement burst_cnt and go to AR if the result is !=0; otherwise it SHALL go to IDLE and pulse done_o for one cycle.
REQ-020 SHALL, if en_i=0 at burst end, go to IDLE without a done_o pulse, and SHALL never abandon a burst mid-flight.
REQ-021 SHALL drive pix_valid_o = FIFO non-empty and pix_data_o = FIFO head (first-word-fall-through).
REQ-022 SHALL pop the FIFO when pix_valid_o=1 and pix_ready_i=1.
REQ-023 SHALL allow a push and a pop in the same cycle, with the level unchanged.
REQ-024 SHALL drive busy_o = (state!=IDLE) or FIFO non-empty.
REQ-025 SHALL add no bubble between the last R beat of one burst and arvalid of the next, provided space exists.

Reset
REQ-026 SHALL, on areset=1 at a rising aclk edge:
- state=IDLE.
- arvalid=0, rready=0.
- pix_valid_o=0.
- done_o=0, err_o=0.
- FIFO empty.
- counters, araddr, arlen, arsize, arburst, arid = 0.
REQ-027 SHALL apply reset even mid-burst; outstanding R beats arriving after reset SHALL be ignored (rready=0).
REQ-028 SHALL clear err_o only by reset.

Verification
REQ-029 Bench SHALL cover basic frame:
- Stimulus: BURST_LEN=16, base=0x8000_0000, frame_bytes=256, memory model with arready=1, pix_ready_i=1.
- Response: 2 ARs at 0x8000_0000 and 0x8000_0080, arlen=15; 32 pixels in address order; one done_o pulse; err_o=0.
REQ-030 Bench SHALL cover backpressure:
- Stimulus: pix_ready_i=0 and frame_bytes=1024.
- Response: exactly 4 ARs issued (FIFO full at 64 entries), then arvalid stays 0 until pops free 16 entries.
REQ-031 Bench SHALL cover arready stall:
- Stimulus: arready held 0 for 5 cycles.
- Response: arvalid=1 with araddr stable across all 5 cycles.
REQ-032 Bench SHALL cover error response:
- Stimulus: rresp=SLVERR on beat 3.
- Response: err_o=1 and sticky, all 16 beats still delivered, done_o still pulses.
REQ-033 Bench SHALL cover reset mid-burst:
- Stimulus: areset during beat 7.
- Response: next cycle has all outputs at reset values; a fresh frame_start_i runs cleanly.
REQ-034 Bench SHALL cover ignored trigger:
- Stimulus: frame_start_i pulse during R.
- Response: no extra AR and burst count unchanged.
